// File: rtl/motor_ramp_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : motor_pkg
// Description : Shared definitions for the motor ramp controller: duty width
//               and default step/limit values, the FSM state encoding and a
//               helper that moves a duty value one step toward a goal.
// Revision    : 1.0 - initial release
//==============================================================================
package motor_pkg;

  localparam int unsigned c_duty_width = 32;
  localparam int unsigned c_duty_step  = 200000;
  localparam int unsigned c_duty_max   = 1800000;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_BRAKE = 2'd2,
    ST_DEAD  = 2'd3
  } motor_state_e;

  // One step from cur toward goal, never overshooting goal. The upward sum is
  // carried in one extra bit so a large step cannot wrap past zero.
  function automatic logic [c_duty_width-1:0] step_toward(
    input logic [c_duty_width-1:0] cur,
    input logic [c_duty_width-1:0] goal,
    input logic [c_duty_width-1:0] step
  );
    logic [c_duty_width:0]   sum;
    logic [c_duty_width-1:0] result;
    sum    = {1'b0, cur} + {1'b0, step};
    result = cur;
    if (cur < goal) begin
      result = (sum > {1'b0, goal}) ? goal : sum[c_duty_width-1:0];
    end else if (cur > goal) begin
      result = ((cur - goal) < step) ? goal : (cur - step);
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_ramp_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : motor_ramp_ctrl_if
// Description : Control/status bundle between the button/PWM side and the
//               motor ramp controller.
//               speedUp, slowDown, dirSwitch : raw push-buttons (async)
//               frameTick                    : one-cycle PWM period-wrap pulse
//               duty                         : registered PWM compare value
//               direction1/direction2        : H-bridge leg A / leg B enables
//               busy                         : controller not in HOLD
//               master = stimulus side, slave = controller side.
// Revision    : 1.0 - initial release
//==============================================================================
interface motor_ramp_ctrl_if;
  import motor_pkg::*;

  logic                    speedUp;
  logic                    slowDown;
  logic                    dirSwitch;
  logic                    frameTick;
  logic [c_duty_width-1:0] duty;
  logic                    direction1;
  logic                    direction2;
  logic                    busy;

  modport master (
    output speedUp, slowDown, dirSwitch, frameTick,
    input  duty, direction1, direction2, busy
  );

  modport slave (
    input  speedUp, slowDown, dirSwitch, frameTick,
    output duty, direction1, direction2, busy
  );

endinterface
`default_nettype wire

// File: rtl/motor_ramp_ctrl_btn_cond.sv
`default_nettype none
//==============================================================================
// Module      : btn_cond
// Description : Push-button conditioner: 2-flop synchronizer, optional
//               debounce filter (macro MOTOR_DEBOUNCE_EN) and rising-edge
//               detector producing a one-cycle press pulse.
//               clk     : clock
//               reset   : synchronous active-high reset
//               i_btn   : raw asynchronous button level
//               o_press : one-cycle pulse per accepted press
// Revision    : 1.0 - initial release
//==============================================================================
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic w_level;

`ifdef MOTOR_DEBOUNCE_EN
  localparam int unsigned c_dbc_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_dbc_w-1:0] c_dbc_last = c_dbc_w'(DEBOUNCE_CYCLES - 1);

  logic               stable_q, stable_d;
  logic [c_dbc_w-1:0] dbc_cnt_q, dbc_cnt_d;

  // The filtered level only follows the synchronized input after it has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any bounce
  // back restarts the count.
  always_comb begin
    stable_d  = stable_q;
    dbc_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (dbc_cnt_q == c_dbc_last) begin
        stable_d = sync2_q;
      end else begin
        dbc_cnt_d = dbc_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q  <= 1'b0;
      dbc_cnt_q <= '0;
    end else begin
      stable_q  <= stable_d;
      dbc_cnt_q <= dbc_cnt_d;
    end
  end

  assign w_level = stable_q;
`else
  // Filter length only matters in the debounced build.
  logic w_unused_debounce;
  assign w_unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign w_level           = sync2_q;
`endif

  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    prev_d  = w_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign o_press = w_level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : motor_ramp_ctrl
// Description : DC motor speed ramp and direction-reversal controller. Button
//               presses set a target duty; the duty output ramps toward it one
//               step per RAMP_FRAMES PWM frames. A reversal brakes to zero,
//               holds both bridge legs off for DEAD_FRAMES frames, flips the
//               direction and ramps back to the target.
//               clk   : clock (rising edge)
//               reset : synchronous active-high reset
//               bus   : motor_ramp_ctrl_if.slave (buttons, frameTick, duty,
//                       direction1/2, busy)
//               Optional macro MOTOR_DEBOUNCE_EN adds a debounce filter to
//               every button.
// Revision    : 1.0 - initial release
//==============================================================================
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned DUTY_STEP       = c_duty_step,
  parameter int unsigned DUTY_MAX        = c_duty_max,
  parameter int unsigned RAMP_FRAMES     = 4,
  parameter int unsigned DEAD_FRAMES     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  motor_ramp_ctrl_if.slave bus
);

  localparam int unsigned c_dw = c_duty_width;
  localparam logic [c_dw-1:0] c_step = c_dw'(DUTY_STEP);
  localparam logic [c_dw-1:0] c_max  = c_dw'(DUTY_MAX);

  localparam int unsigned c_frames_max = (RAMP_FRAMES > DEAD_FRAMES) ? RAMP_FRAMES : DEAD_FRAMES;
  localparam int unsigned c_cnt_w      = (c_frames_max > 1) ? $clog2(c_frames_max) : 1;
  localparam logic [c_cnt_w-1:0] c_ramp_last = c_cnt_w'(RAMP_FRAMES - 1);
  localparam logic [c_cnt_w-1:0] c_dead_last = c_cnt_w'(DEAD_FRAMES - 1);

  localparam logic [1:0] S_HOLD  = ST_HOLD;
  localparam logic [1:0] S_RAMP  = ST_RAMP;
  localparam logic [1:0] S_BRAKE = ST_BRAKE;
  localparam logic [1:0] S_DEAD  = ST_DEAD;

  logic w_press_up, w_press_dn, w_press_dir;

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk(clk), .reset(reset), .i_btn(bus.speedUp), .o_press(w_press_up)
  );
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dn (
    .clk(clk), .reset(reset), .i_btn(bus.slowDown), .o_press(w_press_dn)
  );
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dir (
    .clk(clk), .reset(reset), .i_btn(bus.dirSwitch), .o_press(w_press_dir)
  );

  logic [1:0]         state_q,  state_d;
  logic [c_dw-1:0]    target_q, target_d;
  logic [c_dw-1:0]    duty_q,   duty_d;
  logic [c_cnt_w-1:0] frame_q,  frame_d;
  logic               fwd_q,    fwd_d;   // 1: leg A drives after reversal settles
  logic               dir1_q,   dir1_d;
  logic               dir2_q,   dir2_d;

  logic [c_dw:0] w_target_sum;

  // Target: simultaneous up/down presses cancel. Sum carried in c_dw+1 bits.
  always_comb begin
    target_d     = target_q;
    w_target_sum = {1'b0, target_q} + {1'b0, c_step};
    if (w_press_up && !w_press_dn) begin
      target_d = (w_target_sum > {1'b0, c_max}) ? c_max : w_target_sum[c_dw-1:0];
    end else if (w_press_dn && !w_press_up) begin
      target_d = (target_q < c_step) ? '0 : (target_q - c_step);
    end
  end

  // Duty only moves on a frameTick cycle, so the PWM sees the new value from
  // the start of the next period. The frame divider is cleared on every state
  // transition so each state starts a full cadence.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    frame_d = frame_q;
    fwd_d   = fwd_q;
    dir1_d  = dir1_q;
    dir2_d  = dir2_q;
    case (state_q)
      S_HOLD: begin
        if (w_press_dir) begin
          state_d = S_BRAKE;
          frame_d = '0;
        end else if (duty_q != target_q) begin
          state_d = S_RAMP;
          frame_d = '0;
        end
      end
      S_RAMP: begin
        if (w_press_dir) begin
          state_d = S_BRAKE;
          frame_d = '0;
        end else if (duty_q == target_q) begin
          state_d = S_HOLD;
          frame_d = '0;
        end else if (bus.frameTick) begin
          if (frame_q == c_ramp_last) begin
            duty_d  = step_toward(duty_q, target_q, c_step);
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      S_BRAKE: begin
        if (duty_q == '0) begin
          state_d = S_DEAD;
          frame_d = '0;
          dir1_d  = 1'b0;
          dir2_d  = 1'b0;
        end else if (bus.frameTick) begin
          if (frame_q == c_ramp_last) begin
            duty_d  = step_toward(duty_q, '0, c_step);
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      S_DEAD: begin
        if (bus.frameTick) begin
          if (frame_q == c_dead_last) begin
            state_d = S_RAMP;
            frame_d = '0;
            fwd_d   = ~fwd_q;
            dir1_d  = ~fwd_q;
            dir2_d  = fwd_q;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_HOLD;
        frame_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_HOLD;
      target_q <= '0;
      duty_q   <= '0;
      frame_q  <= '0;
      fwd_q    <= 1'b0;
      dir1_q   <= 1'b0;
      dir2_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      frame_q  <= frame_d;
      fwd_q    <= fwd_d;
      dir1_q   <= dir1_d;
      dir2_q   <= dir2_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.direction1 = dir1_q;
  assign bus.direction2 = dir2_q;
  assign bus.busy       = (state_q != S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_motor_ramp_ctrl
// Description : Directed self-checking bench for motor_ramp_ctrl with default
//               parameters (step 200000, max 1800000, 4 ramp frames, 8 dead
//               frames).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_motor_ramp_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  motor_ramp_ctrl_if bus ();

  motor_ramp_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Continuous invariants: legs never both on; duty moves only after an edge
  // that saw frameTick (or reset).
  logic        ft_s, rst_s;
  logic [31:0] prev_duty;
  always @(posedge clk) begin
    ft_s  <= bus.frameTick;
    rst_s <= reset;
  end
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.direction1 && bus.direction2) begin
        failures = failures + 1;
        $display("FAIL dir_exclusive: direction1=%0b direction2=%0b required not both 1",
                 bus.direction1, bus.direction2);
      end
      if (bus.duty !== prev_duty && !ft_s && !rst_s) begin
        failures = failures + 1;
        $display("FAIL duty_frame_aligned: duty %0d -> %0d without frameTick", prev_duty, bus.duty);
      end
    end
    prev_duty = bus.duty;
  end

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk) bus.frameTick = 1'b1;
      @(negedge clk) bus.frameTick = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  // which: 0 speedUp, 1 slowDown, 2 dirSwitch, 3 speedUp+slowDown together
  task automatic press(input int which);
    @(negedge clk);
    bus.speedUp   = (which == 0 || which == 3);
    bus.slowDown  = (which == 1 || which == 3);
    bus.dirSwitch = (which == 2);
    repeat (4) @(negedge clk);
    bus.speedUp   = 1'b0;
    bus.slowDown  = 1'b0;
    bus.dirSwitch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks = checks + 4;
    if (bus.duty !== 32'd0) begin failures++; $display("FAIL reset_duty: got %0d expected 0", bus.duty); end
    if ({bus.direction1, bus.direction2} !== 2'b01) begin
      failures++; $display("FAIL reset_dir: got %b expected 01", {bus.direction1, bus.direction2});
    end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (dut.target_q !== 32'd0) begin failures++; $display("FAIL reset_target: got %0d expected 0", dut.target_q); end
    reset  = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_ramp_up();
    @(negedge clk) bus.speedUp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut.target_q !== 32'd0) begin failures++; $display("FAIL latency_early: target %0d expected 0", dut.target_q); end
    @(negedge clk);
    checks++;
    if (dut.target_q !== 32'd200000) begin failures++; $display("FAIL latency_3cyc: target %0d expected 200000", dut.target_q); end
    @(negedge clk);
    @(negedge clk) bus.speedUp = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL ramp_busy_start: got %b expected 1", bus.busy); end
    press(0);
    press(0);
    checks++;
    if (dut.target_q !== 32'd600000) begin failures++; $display("FAIL ramp_target: got %0d expected 600000", dut.target_q); end
    for (int s = 1; s <= 3; s++) begin
      frames(3);
      checks++;
      if (bus.duty !== 32'((s - 1) * 200000)) begin
        failures++; $display("FAIL ramp_hold_step%0d: got %0d expected %0d", s, bus.duty, (s - 1) * 200000);
      end
      frames(1);
      checks++;
      if (bus.duty !== 32'(s * 200000)) begin
        failures++; $display("FAIL ramp_step%0d: got %0d expected %0d", s, bus.duty, s * 200000);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_saturate();
    repeat (10) press(0);
    checks++;
    if (dut.target_q !== 32'd1800000) begin failures++; $display("FAIL sat_target_max: got %0d expected 1800000", dut.target_q); end
    frames(23);
    checks++;
    if (bus.duty !== 32'd1600000) begin failures++; $display("FAIL sat_duty_pre: got %0d expected 1600000", bus.duty); end
    frames(1);
    checks = checks + 2;
    if (bus.duty !== 32'd1800000) begin failures++; $display("FAIL sat_duty_max: got %0d expected 1800000", bus.duty); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL sat_busy_max: got %b expected 0", bus.busy); end
    repeat (10) press(1);
    checks++;
    if (dut.target_q !== 32'd0) begin failures++; $display("FAIL sat_target_zero: got %0d expected 0", dut.target_q); end
    frames(4);
    checks++;
    if (bus.duty !== 32'd1600000) begin failures++; $display("FAIL sat_down_first: got %0d expected 1600000", bus.duty); end
    frames(32);
    checks = checks + 3;
    if (bus.duty !== 32'd0) begin failures++; $display("FAIL sat_duty_zero: got %0d expected 0", bus.duty); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL sat_busy_zero: got %b expected 0", bus.busy); end
    if ({bus.direction1, bus.direction2} !== 2'b01) begin
      failures++; $display("FAIL sat_dir: got %b expected 01", {bus.direction1, bus.direction2});
    end
  endtask

  task automatic test_simultaneous();
    press(0);
    press(0);
    frames(8);
    checks++;
    if (bus.duty !== 32'd400000) begin failures++; $display("FAIL simul_setup_duty: got %0d expected 400000", bus.duty); end
    press(3);
    checks = checks + 2;
    if (dut.target_q !== 32'd400000) begin failures++; $display("FAIL simul_target: got %0d expected 400000", dut.target_q); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL simul_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reversal();
    press(2);
    checks = checks + 2;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rev_busy: got %b expected 1", bus.busy); end
    if ({bus.direction1, bus.direction2} !== 2'b01) begin
      failures++; $display("FAIL rev_dir_brake: got %b expected 01", {bus.direction1, bus.direction2});
    end
    frames(4);
    checks++;
    if (bus.duty !== 32'd200000) begin failures++; $display("FAIL rev_brake1: got %0d expected 200000", bus.duty); end
    frames(4);
    checks = checks + 2;
    if (bus.duty !== 32'd0) begin failures++; $display("FAIL rev_brake0: got %0d expected 0", bus.duty); end
    if ({bus.direction1, bus.direction2} !== 2'b00) begin
      failures++; $display("FAIL rev_dead_dir: got %b expected 00", {bus.direction1, bus.direction2});
    end
    press(2);
    frames(7);
    checks = checks + 2;
    if ({bus.direction1, bus.direction2} !== 2'b00) begin
      failures++; $display("FAIL rev_dead_hold: got %b expected 00", {bus.direction1, bus.direction2});
    end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rev_dead_busy: got %b expected 1", bus.busy); end
    frames(1);
    checks = checks + 2;
    if ({bus.direction1, bus.direction2} !== 2'b10) begin
      failures++; $display("FAIL rev_new_dir: got %b expected 10", {bus.direction1, bus.direction2});
    end
    if (bus.duty !== 32'd0) begin failures++; $display("FAIL rev_exit_duty: got %0d expected 0", bus.duty); end
    frames(4);
    checks++;
    if (bus.duty !== 32'd200000) begin failures++; $display("FAIL rev_resume1: got %0d expected 200000", bus.duty); end
    frames(4);
    checks = checks + 3;
    if (bus.duty !== 32'd400000) begin failures++; $display("FAIL rev_resume2: got %0d expected 400000", bus.duty); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rev_busy_end: got %b expected 0", bus.busy); end
    if ({bus.direction1, bus.direction2} !== 2'b10) begin
      failures++; $display("FAIL rev_dir_end: got %b expected 10", {bus.direction1, bus.direction2});
    end
  endtask

  task automatic test_reset_in_dead();
    press(2);
    frames(8);
    checks++;
    if ({bus.direction1, bus.direction2} !== 2'b00) begin
      failures++; $display("FAIL rid_dead_dir: got %b expected 00", {bus.direction1, bus.direction2});
    end
    press(0);
    checks++;
    if (dut.target_q !== 32'd600000) begin failures++; $display("FAIL rid_target_in_dead: got %0d expected 600000", dut.target_q); end
    frames(2);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    checks = checks + 4;
    if (bus.duty !== 32'd0) begin failures++; $display("FAIL rid_duty: got %0d expected 0", bus.duty); end
    if ({bus.direction1, bus.direction2} !== 2'b01) begin
      failures++; $display("FAIL rid_dir: got %b expected 01", {bus.direction1, bus.direction2});
    end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rid_busy: got %b expected 0", bus.busy); end
    if (dut.target_q !== 32'd0) begin failures++; $display("FAIL rid_target: got %0d expected 0", dut.target_q); end
    reset = 1'b0;
    frames(2);
    checks = checks + 2;
    if (bus.duty !== 32'd0) begin failures++; $display("FAIL rid_after_duty: got %0d expected 0", bus.duty); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rid_after_busy: got %b expected 0", bus.busy); end
  endtask

  initial begin
    bus.speedUp   = 1'b0;
    bus.slowDown  = 1'b0;
    bus.dirSwitch = 1'b0;
    bus.frameTick = 1'b0;
    test_reset();
    test_ramp_up();
    test_saturate();
    test_simultaneous();
    test_reversal();
    test_reset_in_dead();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
